// File: rtl/run_limit_serializer.sv
// run_limit_serializer: shifts parallel words out MSB first, one bit per
// clock, inserting a complement stuff bit after every RUN_MAX identical
// line bits so no run on the line ever exceeds RUN_MAX.
//
//   state | meaning
//   IDLE  | waiting for a word; o_ready=1, line holds last bit
//   SEND  | emitting the MSB of the shift register
//   STUFF | emitting one complement bit to break a maximal run
module run_limit_serializer #(
  parameter int DATA_W  = 4,
  parameter int RUN_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_bit,
  output logic              o_bit_valid,
  output logic              o_stuffed,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LIM  = RUN_W'(RUN_MAX);

  typedef enum logic [1:0] {IDLE, SEND, STUFF} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  // bits still to send, counted down to zero
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              last_bit, last_bit_nxt;
  logic [RUN_W-1:0]  run_cnt, run_cnt_nxt;
  logic [RUN_W-1:0]  run_inc;
  logic              data_bit;

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
      run_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      last_bit <= last_bit_nxt;
      run_cnt  <= run_cnt_nxt;
    end
  end

  assign data_bit = shreg[DATA_W-1];
  // run length if data_bit goes on the line this cycle
  assign run_inc  = (data_bit == last_bit && run_cnt != '0) ? run_cnt + RUN_ONE : RUN_ONE;

  // next-state, datapath update and line outputs
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    last_bit_nxt = last_bit;
    run_cnt_nxt  = run_cnt;
    o_ready      = 1'b0;
    o_busy       = 1'b1;
    o_bit        = last_bit;   // idle line holds the last bit sent
    o_bit_valid  = 1'b0;
    o_stuffed    = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (i_valid) begin
          shreg_nxt   = i_data;
          bit_cnt_nxt = CNT_FULL;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        o_bit        = data_bit;
        o_bit_valid  = 1'b1;
        last_bit_nxt = data_bit;
        run_cnt_nxt  = run_inc;
        shreg_nxt    = {shreg[DATA_W-2:0], 1'b0};
        bit_cnt_nxt  = bit_cnt - CNT_ONE;
        if (run_inc == RUN_LIM)
          state_nxt = STUFF;
        else if (bit_cnt == CNT_ONE)
          state_nxt = IDLE;
      end
      STUFF: begin
        o_bit        = ~last_bit;
        o_bit_valid  = 1'b1;
        o_stuffed    = 1'b1;
        last_bit_nxt = ~last_bit;
        run_cnt_nxt  = RUN_ONE;
        state_nxt    = (bit_cnt != '0) ? SEND : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_limit_serializer.sv
// Bench for run_limit_serializer: directed sequences from the test plan
// plus 200 random words against a queue-based line model.
module tb_run_limit_serializer;

  localparam int DATA_W  = 4;
  localparam int RUN_MAX = 3;

  logic clk = 1'b0;
  logic rst, i_valid;
  logic [DATA_W-1:0] i_data;
  logic o_ready, o_bit, o_bit_valid, o_stuffed, o_busy;

  run_limit_serializer #(.DATA_W(DATA_W), .RUN_MAX(RUN_MAX)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_bit(o_bit), .o_bit_valid(o_bit_valid),
    .o_stuffed(o_stuffed), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // line model: run state of the continuous line, expected {stuffed,bit} list
  int m_last = 0;
  int m_run  = 0;
  logic [1:0] exp_q[$];

  function automatic void model_word(input logic [DATA_W-1:0] w);
    int b;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b = int'(w[i]);
      if (m_run > 0 && b == m_last) m_run++;
      else m_run = 1;
      m_last = b;
      exp_q.push_back({1'b0, w[i]});
      if (m_run == RUN_MAX) begin
        m_last = 1 - b;
        m_run  = 1;
        exp_q.push_back({1'b1, ~w[i]});
      end
    end
  endfunction

  // downstream window detector over observed valid line bits
  int   det_run  = 0;
  logic det_last = 1'b0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last = 0; m_run = 0;
    det_run = 0; det_last = 1'b0;
  endtask

  // called at a negedge with the DUT idle; returns at a negedge after the
  // post-word idle cycle has been checked
  task automatic send_word(input logic [DATA_W-1:0] w, input bit hold,
                           output logic [15:0] seq, output logic [15:0] stf);
    logic [DATA_W-1:0] rebuilt;
    logic [1:0] e;
    int n;
    i_valid = 1'b1;
    i_data  = w;
    chk("ready_before", 32'(o_ready), 32'd1);
    exp_q.delete();
    model_word(w);
    n = exp_q.size();
    @(posedge clk);
    seq = '0; stf = '0; rebuilt = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (hold) begin
        i_valid = 1'b1;
        i_data  = DATA_W'($urandom);
      end else begin
        i_valid = 1'b0;
      end
      e = exp_q[k];
      chk("bit_valid", 32'(o_bit_valid), 32'd1);
      chk("bit", 32'(o_bit), 32'(e[0]));
      chk("stuffed", 32'(o_stuffed), 32'(e[1]));
      chk("busy", 32'(o_busy), 32'd1);
      chk("ready_busy", 32'(o_ready), 32'd0);
      seq = {seq[14:0], o_bit};
      stf = {stf[14:0], o_stuffed};
      if (o_bit_valid) begin
        if (det_run > 0 && o_bit == det_last) det_run++;
        else det_run = 1;
        det_last = o_bit;
        chk("run_window", 32'(det_run <= RUN_MAX), 32'd1);
        if (!o_stuffed) rebuilt = {rebuilt[DATA_W-2:0], o_bit};
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    chk("idle_valid", 32'(o_bit_valid), 32'd0);
    chk("idle_ready", 32'(o_ready), 32'd1);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_hold", 32'(o_bit), 32'(exp_q[n-1][0]));
    chk("destuffed", 32'(rebuilt), 32'(w));
  endtask

  logic [15:0] seq, stf;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = '0;
    do_reset();
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_bit", 32'(o_bit), 32'd0);
    chk("rst_valid", 32'(o_bit_valid), 32'd0);
    chk("rst_stuffed", 32'(o_stuffed), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    send_word(4'b1000, 1'b0, seq, stf);
    chk("w1000_seq", 32'(seq), 32'b10001);
    chk("w1000_stf", 32'(stf), 32'b00001);
    send_word(4'b0111, 1'b0, seq, stf);
    chk("w0111_seq", 32'(seq), 32'b01110);
    chk("w0111_stf", 32'(stf), 32'b00001);
    send_word(4'b1010, 1'b0, seq, stf);
    chk("w1010_seq", 32'(seq), 32'b1010);
    chk("w1010_stf", 32'(stf), 32'b0000);

    do_reset();
    send_word(4'b0000, 1'b0, seq, stf);
    chk("w0000_seq", 32'(seq), 32'b00010);
    chk("w0000_stf", 32'(stf), 32'b00010);
    send_word(4'b0011, 1'b0, seq, stf);
    chk("w0011_seq", 32'(seq), 32'b001110);
    chk("w0011_stf", 32'(stf), 32'b001001);

    // i_valid held high with changing data while busy
    send_word(4'b0101, 1'b1, seq, stf);
    chk("hold0101_seq", 32'(seq), 32'b0101);
    chk("hold0101_stf", 32'(stf), 32'b0000);
    send_word(4'b1100, 1'b1, seq, stf);
    chk("hold1100_seq", 32'(seq), 32'b110001);
    chk("hold1100_stf", 32'(stf), 32'b001001);

    // reset on the second output bit of 4'b1111
    i_valid = 1'b1;
    i_data  = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk("mid_bit1", 32'(o_bit), 32'd1);
    @(negedge clk);
    chk("mid_bit2", 32'(o_bit), 32'd1);
    chk("mid_valid2", 32'(o_bit_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last = 0; m_run = 0; det_run = 0; det_last = 1'b0;
    chk("mid_rst_valid", 32'(o_bit_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_bit", 32'(o_bit), 32'd0);
    send_word(4'b1110, 1'b0, seq, stf);
    chk("w1110_seq", 32'(seq), 32'b11100);
    chk("w1110_stf", 32'(stf), 32'b00010);

    // random words with random idle gaps and random busy-time noise
    for (int r = 0; r < 200; r++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        i_data = DATA_W'($urandom);
        @(negedge clk);
        chk("gap_valid", 32'(o_bit_valid), 32'd0);
      end
      send_word(DATA_W'($urandom), bit'($urandom_range(0, 1)), seq, stf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
